// File: rtl/myproject_sdiv_18s_8s_16_seq.sv
// myproject_sdiv_18s_8s_16_seq: sequential radix-2 restoring signed divider
// Ports: ap_clk/ap_rst_n clock and async active-low reset; ce clock enable;
//   din_vld/din_rdy/din0/din1 operand handshake (signed dividend, divisor);
//   dout_vld/dout_rdy/dout/rem/dbz/ovf result handshake (quotient, remainder,
//   divide-by-zero and overflow flags, all qualified by dout_vld).
// Build option: MYPROJECT_SDIV_SAT_EN saturates an overflowing quotient
//   instead of returning its low dout_WIDTH bits.
module myproject_sdiv_18s_8s_16_seq #(
    parameter int din0_WIDTH = 18,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  din_vld,
    output logic                  din_rdy,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  dout_vld,
    input  logic                  dout_rdy,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  dbz,
    output logic                  ovf
);
    localparam int CW = $clog2(din0_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(din0_WIDTH - 1);
    localparam logic signed [din0_WIDTH:0] QMAX = (din0_WIDTH + 1)'(2 ** (dout_WIDTH - 1) - 1);
    localparam logic signed [din0_WIDTH:0] QMIN = -(din0_WIDTH + 1)'(2 ** (dout_WIDTH - 1));
    localparam logic [dout_WIDTH-1:0] DMAX = {1'b0, {(dout_WIDTH - 1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] DMIN = {1'b1, {(dout_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt;
    logic                    sign_q, sign_r;
    // acc shifts the dividend magnitude out at the top while quotient bits
    // shift in at the bottom; after din0_WIDTH steps it holds |quotient|.
    logic [din0_WIDTH-1:0]   acc;
    logic [din1_WIDTH-1:0]   dvs, prem;
    logic [din0_WIDTH-1:0]   mag0;
    logic [din1_WIDTH-1:0]   mag1;
    logic [din1_WIDTH:0]     trial;
    logic                    fits;
    logic [din1_WIDTH-1:0]   prem_nxt;
    logic [din0_WIDTH:0]     qs;
    logic                    ovf_c;
    logic [din1_WIDTH-1:0]   rem_c;
    logic [dout_WIDTH-1:0]   dout_fin;

    assign din_rdy  = (state == IDLE) & ce;
    assign mag0     = din0[din0_WIDTH-1] ? -din0 : din0;
    assign mag1     = din1[din1_WIDTH-1] ? -din1 : din1;
    assign trial    = {prem, acc[din0_WIDTH-1]};
    assign fits     = trial >= {1'b0, dvs};
    // The partial remainder stays below |divisor|, so the trial value never
    // needs its top bit after a successful subtract.
    assign prem_nxt = fits ? trial[din1_WIDTH-1:0] - dvs : trial[din1_WIDTH-1:0];
    // One extra bit lets +2^17 (from -2^17 / -1) be represented for the range check.
    assign qs       = sign_q ? -{1'b0, acc} : {1'b0, acc};
    assign ovf_c    = ($signed(qs) > QMAX) || ($signed(qs) < QMIN);
    assign rem_c    = sign_r ? -prem : prem;
`ifdef MYPROJECT_SDIV_SAT_EN
    assign dout_fin = ovf_c ? (sign_q ? DMIN : DMAX) : qs[dout_WIDTH-1:0];
`else
    assign dout_fin = qs[dout_WIDTH-1:0];
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ce) begin
            case (state)
                IDLE:    state_nxt = din_vld ? ((din1 == '0) ? DONE : CALC) : IDLE;
                CALC:    state_nxt = (cnt == LAST) ? FIN : CALC;
                FIN:     state_nxt = DONE;
                DONE:    state_nxt = (dout_vld && dout_rdy) ? IDLE : DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            acc      <= '0;
            dvs      <= '0;
            prem     <= '0;
            dout     <= '0;
            rem      <= '0;
            dbz      <= 1'b0;
            ovf      <= 1'b0;
            dout_vld <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (din_vld) begin
                        sign_q <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                        sign_r <= din0[din0_WIDTH-1];
                        acc    <= mag0;
                        dvs    <= mag1;
                        prem   <= '0;
                        cnt    <= '0;
                        if (din1 == '0) begin
                            dbz  <= 1'b1;
                            ovf  <= 1'b0;
                            rem  <= '0;
                            dout <= din0[din0_WIDTH-1] ? DMIN : DMAX;
                        end
                    end
                end
                CALC: begin
                    acc  <= {acc[din0_WIDTH-2:0], fits};
                    prem <= prem_nxt;
                    cnt  <= cnt + 1'b1;
                end
                FIN: begin
                    dout     <= dout_fin;
                    rem      <= rem_c;
                    ovf      <= ovf_c;
                    dbz      <= 1'b0;
                    dout_vld <= 1'b1;
                end
                // Divide-by-zero enters DONE with dout_vld low; it rises one edge later.
                DONE: dout_vld <= dout_vld ? !dout_rdy : 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_myproject_sdiv_18s_8s_16_seq.sv
// tb_myproject_sdiv_18s_8s_16_seq: randomized and directed checks of the sequential signed divider
module tb_myproject_sdiv_18s_8s_16_seq;
`ifdef MYPROJECT_SDIV_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic               ce = 1'b1;
    logic               din_vld = 1'b0;
    logic               din_rdy;
    logic signed [17:0] din0 = '0;
    logic signed [7:0]  din1 = '0;
    logic               dout_vld;
    logic               dout_rdy = 1'b0;
    logic [15:0]        dout;
    logic [7:0]         rem;
    logic               dbz;
    logic               ovf;

    int cyc = 0;
    int acc_cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    int da[10] = '{1000, -1000, 1000, -1000, -131072, -131072, 32767, 5, 500, -500};
    int db[10] = '{7, 7, -7, -7, 1, -1, 1, -128, 0, 0};
    int dq[10] = '{142, -142, -142, 142, SAT ? -32768 : 0, SAT ? 32767 : 0, 32767, 0, 32767, -32768};
    int dr[10] = '{6, -6, 6, -6, 0, 0, 0, 5, 0, 0};
    int dz[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    int dv[10] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    int dl[10] = '{19, 19, 19, 19, 19, 19, 19, 19, 1, 1};

    myproject_sdiv_18s_8s_16_seq dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce),
        .din_vld(din_vld), .din_rdy(din_rdy), .din0(din0), .din1(din1),
        .dout_vld(dout_vld), .dout_rdy(dout_rdy), .dout(dout), .rem(rem),
        .dbz(dbz), .ovf(ovf)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    // C-style division on plain integers: truncation toward zero, remainder follows dividend.
    function automatic void model(input int a, input int b, output logic [15:0] q,
                                  output logic [7:0] r, output logic z, output logic o);
        int qi, ri;
        if (b == 0) begin
            z = 1'b1; o = 1'b0; r = '0;
            q = (a < 0) ? 16'h8000 : 16'h7fff;
        end else begin
            qi = a / b;
            ri = a % b;
            z = 1'b0;
            o = (qi > 32767) || (qi < -32768);
            r = ri[7:0];
            q = (o && SAT) ? ((qi < 0) ? 16'h8000 : 16'h7fff) : qi[15:0];
        end
    endfunction

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic start_op(input logic signed [17:0] a, input logic signed [7:0] b);
        int k = 0;
        ce = 1'b1;
        while (!din_rdy && k < 100) begin tick(); k++; end
        if (!din_rdy) begin
            n_chk++; n_fail++;
            $display("FAIL din_rdy_timeout: din_rdy=%0b required 1", din_rdy);
        end
        din0 = a; din1 = b; din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_vld(input int stall_pct, output int lat);
        int k = 0;
        while (!dout_vld && k < 500) begin
            ce = ($urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
            tick();
            k++;
        end
        ce = 1'b1;
        if (!dout_vld) begin
            n_chk++; n_fail++;
            $display("FAIL dout_vld_timeout: dout_vld=%0b required 1", dout_vld);
        end
        lat = cyc - acc_cyc;
    endtask

    task automatic finish_op(input int hold);
        repeat (hold) tick();
        dout_rdy = 1'b1;
        tick();
        dout_rdy = 1'b0;
    endtask

    task automatic run_op(input logic signed [17:0] a, input logic signed [7:0] b, input int stall,
                          output logic [15:0] q, output logic [7:0] r, output logic z,
                          output logic o, output int lat);
        start_op(a, b);
        wait_vld(stall, lat);
        q = dout; r = rem; z = dbz; o = ovf;
        finish_op(stall > 0 ? int'($urandom_range(3)) : 0);
    endtask

    task automatic test_reset();
        n_chk++; if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %0b want 0", dout_vld); end
        n_chk++; if (dout !== 16'h0) begin n_fail++; $display("FAIL reset_dout: got %0h want 0", dout); end
        n_chk++; if (rem !== 8'h0) begin n_fail++; $display("FAIL reset_rem: got %0h want 0", rem); end
        n_chk++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %0b want 0", dbz); end
        n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
        n_chk++; if (din_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %0b want 1", din_rdy); end
    endtask

    task automatic test_directed(input int lo, input int hi, input string name);
        logic [15:0] q;
        logic [7:0]  r;
        logic        z, o;
        int          lat;
        for (int i = lo; i <= hi; i++) begin
            run_op(18'(da[i]), 8'(db[i]), 0, q, r, z, o, lat);
            n_chk++; if (q !== 16'(dq[i])) begin n_fail++; $display("FAIL %s_dout %0d/%0d: got %0d want %0d", name, da[i], db[i], $signed(q), dq[i]); end
            n_chk++; if (r !== 8'(dr[i])) begin n_fail++; $display("FAIL %s_rem %0d/%0d: got %0d want %0d", name, da[i], db[i], $signed(r), dr[i]); end
            n_chk++; if (z !== 1'(dz[i])) begin n_fail++; $display("FAIL %s_dbz %0d/%0d: got %0b want %0d", name, da[i], db[i], z, dz[i]); end
            n_chk++; if (o !== 1'(dv[i])) begin n_fail++; $display("FAIL %s_ovf %0d/%0d: got %0b want %0d", name, da[i], db[i], o, dv[i]); end
            n_chk++; if (lat != dl[i]) begin n_fail++; $display("FAIL %s_latency %0d/%0d: got %0d want %0d", name, da[i], db[i], lat, dl[i]); end
        end
    endtask

    task automatic test_back_to_back_pressure();
        int lat;
        int bad = 0;
        start_op(18'sd1000, 8'sd7);
        wait_vld(0, lat);
        dout_rdy = 1'b0;
        repeat (50) begin
            tick();
            if (dout_vld !== 1'b1 || dout !== 16'd142 || rem !== 8'd6 || din_rdy !== 1'b0) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL backpressure_hold: %0d bad cycles, want 0", bad); end
        dout_rdy = 1'b1;
        tick();
        dout_rdy = 1'b0;
        n_chk++; if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL backpressure_release_vld: got %0b want 0", dout_vld); end
        n_chk++; if (din_rdy !== 1'b1) begin n_fail++; $display("FAIL backpressure_release_rdy: got %0b want 1", din_rdy); end
        n_chk++; if (dout !== 16'd142) begin n_fail++; $display("FAIL backpressure_retain: got %0d want 142", dout); end
    endtask

    task automatic test_ce_stall();
        int lat;
        start_op(-18'sd1000, 8'sd7);
        repeat (5) tick();
        ce = 1'b0;
        repeat (5) tick();
        ce = 1'b1;
        wait_vld(0, lat);
        n_chk++; if (lat != 24) begin n_fail++; $display("FAIL ce_latency: got %0d want 24", lat); end
        n_chk++; if (dout !== 16'hff72) begin n_fail++; $display("FAIL ce_dout: got %0d want -142", $signed(dout)); end
        n_chk++; if (rem !== 8'hfa) begin n_fail++; $display("FAIL ce_rem: got %0d want -6", $signed(rem)); end
        finish_op(0);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        start_op(18'sd1000, 8'sd7);
        repeat (10) tick();
        #2 ap_rst_n = 1'b0;
        #1;
        n_chk++; if ({dout_vld, dout, rem, dbz, ovf} !== '0) begin n_fail++; $display("FAIL midreset_outputs: vld=%0b dout=%0h rem=%0h dbz=%0b ovf=%0b want all 0", dout_vld, dout, rem, dbz, ovf); end
        tick();
        ap_rst_n = 1'b1;
        #1;
        n_chk++; if (din_rdy !== 1'b1) begin n_fail++; $display("FAIL midreset_rdy: got %0b want 1", din_rdy); end
        repeat (40) begin tick(); if (dout_vld !== 1'b0) seen++; end
        n_chk++; if (seen != 0) begin n_fail++; $display("FAIL midreset_stale: dout_vld high %0d cycles, want 0", seen); end
    endtask

    task automatic test_random(input int n);
        logic signed [17:0] a;
        logic signed [7:0]  b;
        logic signed [7:0]  bset[4] = '{8'sd0, 8'sd1, -8'sd1, -8'sd128};
        logic [15:0] q, eq;
        logic [7:0]  r, er;
        logic        z, o, ez, eo;
        int          lat;
        for (int i = 0; i < n; i++) begin
            a = 18'($urandom);
            b = 8'($urandom);
            if ($urandom_range(7) == 0) a = ($urandom_range(1) == 1) ? -18'sd131072 : 18'sd131071;
            if ($urandom_range(5) == 0) b = bset[$urandom_range(3)];
            if ($urandom_range(5) == 0) a = 18'($urandom_range(300)) - 18'sd150;
            model(int'(a), int'(b), eq, er, ez, eo);
            run_op(a, b, 10, q, r, z, o, lat);
            n_chk++; if (q !== eq) begin n_fail++; $display("FAIL rand_dout %0d/%0d: got %0d want %0d", a, b, $signed(q), $signed(eq)); end
            n_chk++; if (r !== er) begin n_fail++; $display("FAIL rand_rem %0d/%0d: got %0d want %0d", a, b, $signed(r), $signed(er)); end
            n_chk++; if (z !== ez) begin n_fail++; $display("FAIL rand_dbz %0d/%0d: got %0b want %0b", a, b, z, ez); end
            n_chk++; if (o !== eo) begin n_fail++; $display("FAIL rand_ovf %0d/%0d: got %0b want %0b", a, b, o, eo); end
        end
    endtask

    initial begin
        repeat (3) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        #1;
        test_reset();
        test_directed(0, 3, "quadrant");
        test_directed(4, 7, "boundary");
        test_directed(8, 9, "div_by_zero");
        test_back_to_back_pressure();
        test_ce_stall();
        test_reset_mid();
        test_random(2000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
